// File: rtl/csr_rmw_seq_if.sv
// csr_rmw_seq_if: request, CSR file, ALU, register-file and status signals of the CSR read-modify-write sequencer
//   slave  : sequencer side (takes the request, reads/writes the CSR, drives the ALU, writes the RF)
//   master : environment side (issues the request, returns CSR read data and ALU result)
interface csr_rmw_seq_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  funct3;
   logic [11:0] csr_addr;
   logic [31:0] rs1_data;
   logic [4:0]  rs1_zimm;
   logic [4:0]  rd;
   logic        csr_rd_en;
   logic [11:0] csr_rd_addr;
   logic [31:0] csr_rd_data;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_op;
   logic [31:0] alu_result;
   logic        csr_wr_en;
   logic [11:0] csr_wr_addr;
   logic [31:0] csr_wr_data;
   logic        rf_wr_en;
   logic [4:0]  rf_wr_addr;
   logic [31:0] rf_wr_data;
   logic        stall;
   logic        done;
   logic        illegal;
   modport slave (
      input  req_valid, funct3, csr_addr, rs1_data, rs1_zimm, rd, csr_rd_data, alu_result,
      output req_ready, csr_rd_en, csr_rd_addr, alu_a, alu_b, alu_op,
             csr_wr_en, csr_wr_addr, csr_wr_data, rf_wr_en, rf_wr_addr, rf_wr_data,
             stall, done, illegal
   );
   modport master (
      output req_valid, funct3, csr_addr, rs1_data, rs1_zimm, rd, csr_rd_data, alu_result,
      input  req_ready, csr_rd_en, csr_rd_addr, alu_a, alu_b, alu_op,
             csr_wr_en, csr_wr_addr, csr_wr_data, rf_wr_en, rf_wr_addr, rf_wr_data,
             stall, done, illegal
   );
endinterface

// File: rtl/csr_rmw_seq.sv
// csr_rmw_seq: four-state CSR read-modify-write sequencer (IDLE -> READ -> EXEC -> WRITE)
//   clock, reset : sole clock, synchronous active-high reset
//   bus          : csr_rmw_seq_if.slave (request, CSR read/write, ALU, RF write, stall/done/illegal)
//   CSR_WRITE_SUPPRESS_EN : when defined, set/clear forms with a zero source skip the CSR write
module csr_rmw_seq (
   input logic          clock,
   input logic          reset,
   csr_rmw_seq_if.slave bus
);
   localparam logic [3:0] ALU_PASS = 4'd0, ALU_OR = 4'd1, ALU_CLEAR = 4'd2;
   typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
   state_t      state, state_nx;
   logic [2:0]  f3;
   logic [11:0] addr;
   logic [31:0] rs1, old, res;
   logic [4:0]  zimm, rd;
   logic        legal, wr_ok;
   // funct3 000 and 100 are the only non-CSR encodings
   assign legal = bus.funct3[1:0] != 2'b00;
`ifdef CSR_WRITE_SUPPRESS_EN
   // funct3[1] marks the set/clear forms; a zero rs1 index or zimm means no side effect
   assign wr_ok = !(f3[1] && zimm == 5'd0);
`else
   assign wr_ok = 1'b1;
`endif
   always_ff @(posedge clock)
      if (reset) state <= IDLE;
      else       state <= state_nx;
   always_ff @(posedge clock)
      if (reset) begin
         f3   <= '0;
         addr <= '0;
         rs1  <= '0;
         zimm <= '0;
         rd   <= '0;
         old  <= '0;
         res  <= '0;
      end else if (state == IDLE && bus.req_valid && legal) begin
         f3   <= bus.funct3;
         addr <= bus.csr_addr;
         rs1  <= bus.rs1_data;
         zimm <= bus.rs1_zimm;
         rd   <= bus.rd;
      end else if (state == EXEC) begin
         old <= bus.csr_rd_data;
         res <= bus.alu_result;
      end
   // every output is gated by reset so an aborted operation never writes or completes
   always_comb begin
      state_nx        = state;
      bus.req_ready   = state == IDLE;
      bus.stall       = 1'b0;
      bus.illegal     = 1'b0;
      bus.csr_rd_en   = 1'b0;
      bus.csr_rd_addr = '0;
      bus.alu_a       = '0;
      bus.alu_b       = '0;
      bus.alu_op      = ALU_PASS;
      bus.csr_wr_en   = 1'b0;
      bus.csr_wr_addr = '0;
      bus.csr_wr_data = '0;
      bus.rf_wr_en    = 1'b0;
      bus.rf_wr_addr  = '0;
      bus.rf_wr_data  = '0;
      bus.done        = 1'b0;
      if (!reset)
         case (state)
            IDLE: if (bus.req_valid) begin
               state_nx    = legal ? READ : IDLE;
               bus.stall   = legal;
               bus.illegal = !legal;
            end
            READ: begin
               state_nx        = EXEC;
               bus.stall       = 1'b1;
               bus.csr_rd_en   = 1'b1;
               bus.csr_rd_addr = addr;
            end
            EXEC: begin
               state_nx   = WRITE;
               bus.stall  = 1'b1;
               bus.alu_a  = f3[2] ? {27'b0, zimm} : rs1;
               bus.alu_b  = bus.csr_rd_data;
               bus.alu_op = f3[1:0] == 2'b01 ? ALU_PASS : f3[1:0] == 2'b10 ? ALU_OR : ALU_CLEAR;
            end
            WRITE: begin
               state_nx        = IDLE;
               bus.csr_wr_en   = wr_ok;
               bus.csr_wr_addr = addr;
               bus.csr_wr_data = res;
               bus.rf_wr_en    = rd != 5'd0;
               bus.rf_wr_addr  = rd;
               bus.rf_wr_data  = old;
               bus.done        = 1'b1;
            end
            default: state_nx = IDLE;
         endcase
   end
endmodule

// File: tb/tb_csr_rmw_seq.sv
// tb_csr_rmw_seq: directed self-checking bench for csr_rmw_seq with CSR-read and ALU responders
module tb_csr_rmw_seq;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] old_val = '0;
   int          n_checks = 0;
   int          n_errors = 0;
   csr_rmw_seq_if bus ();
   csr_rmw_seq dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;
   // CSR file returns old_val one cycle after a read strobe, garbage otherwise
   always @(posedge clock) bus.csr_rd_data <= bus.csr_rd_en ? old_val : 32'hDEAD_BEEF;
   // ALU: 0 = PASS a, 1 = OR, 2 = CLEAR bits of a in b
   assign bus.alu_result = bus.alu_op == 4'd0 ? bus.alu_a :
                           bus.alu_op == 4'd1 ? (bus.alu_a | bus.alu_b) :
                           bus.alu_op == 4'd2 ? (bus.alu_b & ~bus.alu_a) : 32'hBAD0_0000;
`ifdef CSR_WRITE_SUPPRESS_EN
   localparam logic SUP_WR = 1'b0;
`else
   localparam logic SUP_WR = 1'b1;
`endif
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic drive(input logic v, input logic [2:0] f3, input logic [11:0] a, input logic [31:0] r,
                        input logic [4:0] z, input logic [4:0] d);
      bus.req_valid = v;
      bus.funct3    = f3;
      bus.csr_addr  = a;
      bus.rs1_data  = r;
      bus.rs1_zimm  = z;
      bus.rd        = d;
   endtask
   task automatic run_op(input string name, input logic [2:0] f3, input logic [11:0] a, input logic [31:0] r,
                         input logic [4:0] z, input logic [4:0] d, input logic [31:0] old,
                         input logic [3:0] e_op, input logic [31:0] e_a, input logic e_wr,
                         input logic [31:0] e_data);
      old_val = old;
      drive(1'b1, f3, a, r, z, d);
      #1;
      check({name, " T ready"}, bus.req_ready, 1);
      check({name, " T stall"}, bus.stall, 1);
      @(negedge clock);
      bus.req_valid = 1'b0;
      #1;
      check({name, " T+1 rd_en"}, bus.csr_rd_en, 1);
      check({name, " T+1 rd_addr"}, bus.csr_rd_addr, a);
      check({name, " T+1 stall"}, bus.stall, 1);
      check({name, " T+1 ready"}, bus.req_ready, 0);
      @(negedge clock);
      #1;
      check({name, " T+2 alu_a"}, bus.alu_a, e_a);
      check({name, " T+2 alu_b"}, bus.alu_b, old);
      check({name, " T+2 alu_op"}, bus.alu_op, e_op);
      check({name, " T+2 rd_en"}, bus.csr_rd_en, 0);
      @(negedge clock);
      #1;
      check({name, " T+3 done"}, bus.done, 1);
      check({name, " T+3 stall"}, bus.stall, 0);
      check({name, " T+3 wr_en"}, bus.csr_wr_en, e_wr);
      check({name, " T+3 wr_addr"}, bus.csr_wr_addr, a);
      check({name, " T+3 wr_data"}, bus.csr_wr_data, e_data);
      check({name, " T+3 rf_en"}, bus.rf_wr_en, d != 5'd0);
      if (d != 5'd0) begin
         check({name, " T+3 rf_addr"}, bus.rf_wr_addr, d);
         check({name, " T+3 rf_data"}, bus.rf_wr_data, old);
      end
      check({name, " T+3 alu_op idle"}, bus.alu_op, 0);
      @(negedge clock);
      #1;
      check({name, " T+4 done"}, bus.done, 0);
      check({name, " T+4 wr_en"}, bus.csr_wr_en, 0);
      check({name, " T+4 ready"}, bus.req_ready, 1);
   endtask
   initial begin
      logic [7:0] st_v, rdy_v, dn_v;
      drive(1'b1, 3'b001, 12'h300, 32'h1111_1111, 5'd1, 5'd1);
      @(negedge clock);
      @(negedge clock);
      #1;
      check("rst ready", bus.req_ready, 1);
      check("rst stall", bus.stall, 0);
      check("rst rd_en", bus.csr_rd_en, 0);
      check("rst alu_a", bus.alu_a, 0);
      check("rst done", bus.done, 0);
      reset = 1'b0;
      bus.req_valid = 1'b0;
      @(negedge clock);
      #1;
      check("rst prio rd_en", bus.csr_rd_en, 0);
      check("rst prio ready", bus.req_ready, 1);
      run_op("csrrw",  3'b001, 12'h300, 32'h1234_5678, 5'd3,  5'd5,  32'h0000_00AA, 4'd0, 32'h1234_5678, 1'b1,   32'h1234_5678);
      run_op("csrrci", 3'b111, 12'h341, 32'hCAFE_F00D, 5'h0F, 5'd0,  32'hFFFF_FFFF, 4'd2, 32'h0000_000F, 1'b1,   32'hFFFF_FFF0);
      run_op("csrrs0", 3'b010, 12'h305, 32'h0000_0000, 5'd0,  5'd7,  32'h0000_0055, 4'd1, 32'h0000_0000, SUP_WR, 32'h0000_0055);
      run_op("csrrsi", 3'b110, 12'h304, 32'h0000_0000, 5'h11, 5'd1,  32'h0000_0100, 4'd1, 32'h0000_0011, 1'b1,   32'h0000_0111);
      run_op("csrrc",  3'b011, 12'h342, 32'h0000_FF00, 5'd9,  5'd31, 32'h1234_FFFF, 4'd2, 32'h0000_FF00, 1'b1,   32'h1234_00FF);
      run_op("csrrwi", 3'b101, 12'h340, 32'hFFFF_FFFF, 5'h1F, 5'd2,  32'h0000_ABCD, 4'd0, 32'h0000_001F, 1'b1,   32'h0000_001F);
      run_op("csrrci0",3'b111, 12'h343, 32'h0000_0000, 5'd0,  5'd3,  32'h0000_0077, 4'd2, 32'h0000_0000, SUP_WR, 32'h0000_0077);
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, i == 0 ? 3'b100 : 3'b000, 12'h300, 32'h1, 5'd1, 5'd1);
         #1;
         check("ill pulse", bus.illegal, 1);
         check("ill stall", bus.stall, 0);
         check("ill rd_en", bus.csr_rd_en, 0);
         @(negedge clock);
         bus.req_valid = 1'b0;
         #1;
         check("ill after", bus.illegal, 0);
         check("ill ready", bus.req_ready, 1);
         check("ill no rd", bus.csr_rd_en, 0);
      end
      old_val = 32'h0000_0042;
      drive(1'b1, 3'b001, 12'h300, 32'h0BAD_0BAD, 5'd1, 5'd4);
      @(negedge clock);
      bus.req_valid = 1'b0;
      @(negedge clock);
      #1;
      check("abort exec alu_b", bus.alu_b, 32'h0000_0042);
      reset = 1'b1;
      #1;
      check("abort rst alu_a", bus.alu_a, 0);
      check("abort rst stall", bus.stall, 0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("abort idle", bus.req_ready, 1);
      check("abort wr_en", bus.csr_wr_en, 0);
      check("abort rf_en", bus.rf_wr_en, 0);
      check("abort done", bus.done, 0);
      @(negedge clock);
      #1;
      check("abort done2", bus.done, 0);
      check("abort wr_en2", bus.csr_wr_en, 0);
      run_op("post abort", 3'b010, 12'h300, 32'h0000_0F00, 5'd6, 5'd6, 32'h0000_00F0, 4'd1, 32'h0000_0F00, 1'b1, 32'h0000_0FF0);
      old_val = 32'h0000_0001;
      drive(1'b1, 3'b001, 12'h300, 32'h0000_0002, 5'd2, 5'd8);
      for (int i = 0; i < 8; i++) begin
         #1;
         st_v[i]  = bus.stall;
         rdy_v[i] = bus.req_ready;
         dn_v[i]  = bus.done;
         @(negedge clock);
      end
      bus.req_valid = 1'b0;
      #1;
      check("b2b stall", st_v, 8'h77);
      check("b2b ready", rdy_v, 8'h11);
      check("b2b done", dn_v, 8'h88);
      check("b2b end idle", bus.req_ready, 1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/csr_rmw_seq.md
CSR_RMW_SEQ -- requirements
Module: csr_rmw_seq

Interface
REQ-001 SHALL have ports `clock` (in, 1, sole clock) and `reset` (in, 1); reset is synchronous and active-high.
REQ-002 SHALL have `req_valid` (in, 1, CSR instruction present in EX) and `req_ready` (out, 1, request accepted this cycle).
REQ-003 SHALL have `funct3` (in, 3, CSR funct3) and `csr_addr` (in, 12).
REQ-004 SHALL have `rs1_data` (in, 32); `rs1_zimm` (in, 5, rs1 index or zimm); `rd` (in, 5).
REQ-005 SHALL have `csr_rd_en` (out, 1), `csr_rd_addr` (out, 12) and `csr_rd_data` (in, 32, valid one cycle after `csr_rd_en`).
REQ-006 SHALL have `alu_a` (out, 32), `alu_b` (out, 32), `alu_op` (out, 4, ALUOp encoding) and `alu_result` (in, 32, combinational).
REQ-007 SHALL have `csr_wr_en` (out, 1), `csr_wr_addr` (out, 12) and `csr_wr_data` (out, 32).
REQ-008 SHALL have `rf_wr_en` (out, 1), `rf_wr_addr` (out, 5) and `rf_wr_data` (out, 32).
REQ-009 SHALL have `stall` (out, 1), `done` (out, 1, pulse) and `illegal` (out, 1, pulse).

Function
REQ-010 SHALL implement FSM states IDLE, READ, EXEC, WRITE.
REQ-011 SHALL set `req_ready` = (state==IDLE).
REQ-012 IDLE with `req_valid` and a legal funct3 (001,010,011,101,110,111) SHALL latch funct3, csr_addr, rs1_data, rs1_zimm and rd, then go to READ.
REQ-013 IDLE with `req_valid` and funct3 000 or 100 SHALL pulse `illegal` for one cycle and stay in IDLE with no CSR or RF access.
REQ-014 READ SHALL assert `csr_rd_en` with `csr_rd_addr` = latched address for one cycle, then go to EXEC.
REQ-015 EXEC SHALL capture `csr_rd_data` as old value and drive `alu_b` = old value.
REQ-016 EXEC SHALL drive `alu_a` = rs1_data for funct3[2]=0, else {27'b0, zimm}.
REQ-017 EXEC SHALL drive `alu_op` = PASS for CSRRW/CSRRWI, OR for CSRRS/CSRRSI, CLEAR for CSRRC/CSRRCI.
REQ-018 EXEC SHALL register `alu_result`, then go to WRITE.
REQ-019 WRITE SHALL assert `csr_wr_en` for one cycle with registered result, subject to REQ-030/031.
REQ-020 WRITE SHALL assert `rf_wr_en` with `rf_wr_addr` = rd and `rf_wr_data` = old value only when rd != 0.
REQ-021 WRITE SHALL pulse `done` and return to IDLE.
REQ-022 Fixed latency: accept at cycle T -> READ T+1, EXEC T+2, WRITE/`done` T+3; next accept no earlier than T+4.
REQ-023 `stall` SHALL be high in READ and EXEC, and combinationally high in IDLE when a legal request is present; low in WRITE and otherwise.
REQ-024 `req_valid` while not IDLE SHALL be ignored.
REQ-025 `alu_a`, `alu_b` and `alu_op` SHALL be 0 / PASS outside EXEC.
REQ-026 All strobe outputs SHALL be low outside their defined states.

Reset
REQ-027 `reset` SHALL force IDLE and clear all latched registers; all outputs SHALL be 0, except `req_ready` = 1.
REQ-028 Reset in any state, including mid-operation, SHALL abort with no `csr_wr_en`, `rf_wr_en` or `done` in that or the following cycle.
REQ-029 Reset SHALL take priority over a simultaneous `req_valid`.

Configuration
REQ-030 Macro `CSR_WRITE_SUPPRESS_EN` defined: WRITE SHALL suppress `csr_wr_en` when funct3 is CSRRS/CSRRC and rs1_zimm==0, or CSRRSI/CSRRCI and zimm==0; `done` and RF write are unaffected.
REQ-031 Macro `CSR_WRITE_SUPPRESS_EN` undefined: `csr_wr_en` SHALL always assert in WRITE.

Verification
REQ-032 CSRRW: csr 0x300 old=0x0000_00AA, rs1_data=0x1234_5678, rd=5 -> at T+3 csr_wr_data=0x1234_5678, rf_wr x5=0x0000_00AA, done=1.
REQ-033 CSRRCI: old=0xFFFF_FFFF, zimm=0x0F, rd=0 -> csr_wr_data=0xFFFF_FFF0, rf_wr_en=0.
REQ-034 CSRRS: rs1_zimm=0, old=0x55 -> with macro csr_wr_en=0 and rf gets 0x55; without macro csr_wr_en=1 with data 0x55.
REQ-035 funct3=100 with req_valid -> illegal=1 for one cycle, state stays IDLE, no rd/wr strobes, stall=0.
REQ-036 Reset asserted in EXEC -> next cycle IDLE, csr_wr_en/rf_wr_en/done never assert; a new request is then accepted normally.
REQ-037 Back-to-back requests held valid -> second accepted at T+4, and stall pattern per REQ-023.
